// File: rtl/sor_sched_pkg.sv
// Shared types and constants for the sor_left scheduler.
package sor_sched_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 4;

  localparam logic       OP_SHL  = 1'b0;
  localparam logic       OP_ROL  = 1'b1;
  localparam logic [2:0] SEL_MAX = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    PASS1,
    PASS2,
    RESP
  } state_t;

endpackage

// File: rtl/sor_left.sv
// 8-bit combinational left shifter / rotator.
// control = 0: shift left with zero fill; control = 1: rotate left.
module sor_left (
  input  logic [7:0] data,
  input  logic [2:0] select,
  input  logic       control,
  output logic [7:0] sor
);

  logic [15:0] w_dbl;

  // Rotate takes the upper byte of the doubled word; shift drops the overflow.
  always_comb begin
    w_dbl = {data, data} << select;
    if (control) begin
      sor = w_dbl[15:8];
    end else begin
      sor = data << select;
    end
  end

endmodule

// File: rtl/sor_scheduler.sv
// Two-requester scheduler for the shared sor_left datapath.
// Shifts of 8..15 are split into two passes (7, then the remainder).
// Optional macro SOR_SCHED_RR_EN: round-robin arbitration; otherwise req0
// has fixed priority.
module sor_scheduler #(
  parameter int DATA_W = sor_sched_pkg::DATA_W,
  parameter int AMT_W  = sor_sched_pkg::AMT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0]  req1_amt,
  input  logic              req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              busy
);

  import sor_sched_pkg::*;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_result;
  logic [AMT_W-1:0]  r_amt;
  logic              r_op;
  logic              r_id;

  logic              w_grant0;
  logic              w_grant1;
  logic              w_accept;
  logic              w_two_pass;
  logic [AMT_W-1:0]  w_amt_m7;
  logic [2:0]        w_sel;
  logic [DATA_W-1:0] w_sor_in;
  logic [DATA_W-1:0] w_sor_out;

`ifdef SOR_SCHED_RR_EN
  logic r_last_id;

  // Round-robin grant: on contention the requester not served last wins.
  always_comb begin
    w_grant0 = req0_valid & (~req1_valid | r_last_id);
    w_grant1 = req1_valid & (~req0_valid | ~r_last_id);
  end

  // Remember the last accepted requester; reset value makes req0 preferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_id <= 1'b1;
    end else if (w_accept) begin
      r_last_id <= req1_ready;
    end
  end
`else
  // Fixed-priority grant: req0 always wins.
  always_comb begin
    w_grant0 = req0_valid;
    w_grant1 = req1_valid & ~req0_valid;
  end
`endif

  // Handshake outputs; readys are forced low while reset is asserted.
  always_comb begin
    req0_ready = rst_n & (r_state == IDLE) & w_grant0;
    req1_ready = rst_n & (r_state == IDLE) & w_grant1;
    w_accept   = req0_ready | req1_ready;
    rsp_valid  = (r_state == RESP);
    rsp_data   = r_result;
    rsp_id     = r_id;
    busy       = (r_state != IDLE);
  end

  // Datapath select: two-pass shifts use 7 then min(amt-7, 7) on the partial result.
  always_comb begin
    w_two_pass = (r_op == OP_SHL) && (r_amt > AMT_W'(SEL_MAX));
    w_amt_m7   = r_amt - AMT_W'(SEL_MAX);
    w_sor_in   = r_data;
    w_sel      = r_amt[2:0];
    if (r_state == PASS2) begin
      w_sor_in = r_result;
      w_sel    = (w_amt_m7 > AMT_W'(SEL_MAX)) ? SEL_MAX : w_amt_m7[2:0];
    end else if (w_two_pass) begin
      w_sel = SEL_MAX;
    end
  end

  sor_left u_sor_left (
    .data    (w_sor_in),
    .select  (w_sel),
    .control (r_op),
    .sor     (w_sor_out)
  );

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = PASS1;
      PASS1:   w_state_nxt = w_two_pass ? PASS2 : RESP;
      PASS2:   w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the granted request on accept; capture datapath output during passes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_amt    <= '0;
      r_op     <= 1'b0;
      r_id     <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_data <= req1_ready ? req1_data : req0_data;
        r_amt  <= req1_ready ? req1_amt  : req0_amt;
        r_op   <= req1_ready ? req1_op   : req0_op;
        r_id   <= req1_ready;
      end
      if ((r_state == PASS1) || (r_state == PASS2)) begin
        r_result <= w_sor_out;
      end
    end
  end

endmodule

// File: doc/sor_scheduler.md
# sor_scheduler

Shared-resource controller for the 8-bit `sor_left` shift/rotate datapath. It arbitrates between two requesters with valid/ready handshakes and latches the granted operation. It sequences the combinational shifter over one or two passes, so shift amounts up to 15 are supported even though the datapath only takes a 3-bit select. The registered result is returned on a single response channel tagged with the requester ID.

## Interface
- `DATA_W`, 8, operand width; fixed at 8 to match `sor_left`.
- `AMT_W`, 4, request shift/rotate amount width; amount range 0..15.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when high together with valid.
- `req0_data` / `req1_data`  in  DATA_W  operand.
- `req0_amt` / `req1_amt`  in  AMT_W  amount.
- `req0_op` / `req1_op`  in  1  0 = shift left (zero fill), 1 = rotate left.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_data`  out  DATA_W  result.
- `rsp_id`  out  1  requester that issued the result.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States:
  - IDLE: arbitrate and accept.
  - PASS1: first datapath pass.
  - PASS2: second datapath pass, only for shifts of 8..15.
  - RESP: hold result until taken.
- Ready generation:
  - `reqN_ready = (state==IDLE) & grantN`.
  - The grant is combinational from the valids, so a valid-to-ready path exists.
  - At most one ready is high per cycle.
- Accept (IDLE, valid & ready):
  - Latch data into the operand register, plus amt, op and id.
  - Go to PASS1.
- Select generation:
  - Rotate: single pass with select = amt[2:0]. Rotating by 8 is identity, so amt 8..15 is handled as amt mod 8.
  - Shift, amt 0..7: single pass with select = amt[2:0]. Amount 0 passes data through.
  - Shift, amt 8..15: PASS1 select = 7. PASS2 select = min(amt-7, 7), taken from the PASS1 result. The final result is always 0x00.
- PASS1: `sor_left` result written to the result register.
  - Next state is PASS2 if this is a two-pass shift, otherwise RESP.
- PASS2: `sor_left` is fed from the result register and its output written back to the result register; next state RESP.
- RESP: `rsp_valid` high, with `rsp_data`/`rsp_id` held stable.
  - On `rsp_ready`, go to IDLE.
  - No new request is accepted in the same cycle.
- Arbitration pointer:
  - Updated only on accept.
  - Round-robin: the last granted requester becomes lowest priority.
  - After reset, req0 is preferred.

## Timing
- Reset values (async on `rst_n` low):
  - state = IDLE, `rsp_valid` = 0, `rsp_data` = 0x00, `rsp_id` = 0, `busy` = 0, both readys = 0.
  - RR pointer favours req0.
- Single-pass latency: accept at edge t, `rsp_valid` high after edge t+1.
- Two-pass latency: accept at edge t, `rsp_valid` high after edge t+2.
- Response handshake: completes on the edge where `rsp_valid & rsp_ready`; IDLE follows after that edge.
- Minimum spacing between accepts: 3 cycles (single pass with `rsp_ready` held high).
- Reset asserted mid-operation (any state): the in-flight request is dropped with no response; all outputs return to reset values immediately.
- A request that drops valid before being accepted is never issued.

## Configuration
- `SOR_SCHED_RR_EN` defined: round-robin arbitration as described above.
- Not defined: fixed priority, with req0 always winning over req1. The pointer register is removed.

## Structure
- Package `sor_sched_pkg` holds:
  - the state enum (IDLE, PASS1, PASS2, RESP);
  - constants `OP_SHL=1'b0` and `OP_ROL=1'b1`;
  - `DATA_W`/`AMT_W` defaults;
  - constant `SEL_MAX=3'd7`.
- Sub-module: one instance of the existing `sor_left`, with ports data, select, control, sor. Its `control` input is driven by the latched op.
- Arbiter logic stays inline; no further sub-modules.

## Test plan
- Single-pass shift: req0 data 0xA6, amt 6, op 0 → `rsp_data` 0x80, `rsp_id` 0; `rsp_valid` high after edge t+1.
- Rotate with amount ≥ 8: req1 data 0xA6, amt 14, op 1 → single pass, `rsp_data` 0xA9, `rsp_id` 1.
- Two-pass shift: req0 data 0xFF, amt 9, op 0 → two passes, `rsp_data` 0x00; `rsp_valid` high after edge t+2; `busy` high throughout.
- Contention: both valid continuously, `rsp_ready` tied high.
  - With `SOR_SCHED_RR_EN`: `rsp_id` sequence is 0,1,0,1.
  - Without it: `rsp_id` sequence is 0,0,0,0.
- Backpressure: `rsp_ready` held low for 5 cycles in RESP → `rsp_valid`/`rsp_data` held stable, both readys low; IDLE follows on the edge after `rsp_ready` rises.
- Reset mid-operation: `rst_n` pulsed low during PASS2 → all outputs return to reset values immediately and no response is produced. A following request with both requesters valid is granted to req0.
